// File: rtl/seg_scan_sink.sv
// Frame sink for a multiplexed seven-segment display: one pending frame buffer,
// refresh scanning with per-slot anode blanking, frame swaps only at frame boundaries.
module seg_scan_sink #(
  parameter int DIGITS       = 2,
  parameter int SEG_W        = 7,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DIGITS-1:0][SEG_W-1:0]     s_data,
  output logic [SEG_W-1:0]                 seg_n,
  output logic [DIGITS-1:0]                an_n,
  output logic                             frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     C_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]     C_BLANK   = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     I_LAST    = IW'(DIGITS - 1);
  localparam logic [SEG_W-1:0]  SEG_INACT = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] AN_INACT  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIGITS-1:0][SEG_W-1:0] pend_q, pend_d;
  logic [DIGITS-1:0][SEG_W-1:0] disp_q, disp_d;
  logic                         pend_valid_q, pend_valid_d;
  logic [CW-1:0]                c_q, c_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [SEG_W-1:0]             seg_q, seg_d;
  logic [DIGITS-1:0]            an_q, an_d;
  logic                         fs_q, fs_d;

  logic                         blank;
  logic                         boundary;
  logic                         xfer;
  logic [DIGITS-1:0]            an_act;

  assign s_ready  = !pend_valid_q && !rst;
  assign xfer     = s_valid && s_ready;
  assign blank    = (c_q < C_BLANK);
  assign boundary = (c_q == C_LAST) && (idx_q == I_LAST);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
    assign an_act[gi] = !blank && (idx_q == IW'(gi));
  end

  always_comb begin
    c_d          = c_q + 1'b1;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;

    if (c_q == C_LAST) begin
      c_d   = '0;
      idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
    end

    // A transfer needs an empty buffer, so it can never coincide with a swap;
    // a frame arriving on the boundary edge waits a full frame (no bypass).
    if (xfer) begin
      pend_d       = s_data;
      pend_valid_d = 1'b1;
    end else if (boundary && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end

    seg_d = (blank ? '0 : disp_q[idx_q]) ^ SEG_INACT;
    an_d  = an_act ^ AN_INACT;
    fs_d  = (c_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      disp_q       <= '0;
      pend_valid_q <= 1'b0;
      c_q          <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_INACT;
      an_q         <= AN_INACT;
      fs_q         <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      pend_valid_q <= pend_valid_d;
      c_q          <= c_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg_n       = seg_q;
  assign an_n        = an_q;
  assign frame_start = fs_q;

endmodule
